// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: 32-cell character frame buffer that streams changed cells to an HD44780 controller.
// Optional macro LCD_FRAME_WRITER_FULL_REFRESH_EN rewrites every cell continuously instead of only dirty ones.
module lcd_frame_writer #(
   parameter int GAP_CYCLES = 10000,
   parameter int CNT_W      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       host_we,
   input  logic [4:0] host_addr,
   input  logic [7:0] host_data,
   input  logic       lcd_ready,
   output logic [7:0] char_data,
   output logic [4:0] cursor_pos,
   output logic       write_enable,
   output logic       busy
);
   typedef enum logic [1:0] {S_SCAN, S_ISSUE, S_WAIT} state_t;
   state_t           state, state_next;
   logic [7:0]       cells [32];
   logic [31:0]      dirty;
   logic [4:0]       scan_ptr;
   logic [CNT_W-1:0] gap_cnt;
   logic             cell_hit, fire, gap_done, advance;
`ifdef LCD_FRAME_WRITER_FULL_REFRESH_EN
   assign cell_hit = 1'b1;
`else
   assign cell_hit = dirty[scan_ptr];
`endif
   assign fire     = state == S_ISSUE && lcd_ready;
   // The counter leaves WAIT as it reaches zero, giving exactly GAP_CYCLES cycles in WAIT.
   assign gap_done = gap_cnt <= CNT_W'(1);
   assign advance  = (state == S_SCAN && !cell_hit) || (state == S_WAIT && gap_done);
   always_comb begin
      state_next = state;
      case (state)
         S_SCAN:  state_next = cell_hit ? S_ISSUE : S_SCAN;
         S_ISSUE: state_next = lcd_ready ? S_WAIT : S_ISSUE;
         S_WAIT:  state_next = gap_done ? S_SCAN : S_WAIT;
         default: state_next = S_SCAN;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_SCAN;
      else        state <= state_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i < 32; i++) cells[i] <= 8'h20;
      else if (host_we) cells[host_addr] <= host_data;
   // A host set in the fire cycle wins over the clear, so the new value goes out on a later pass.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dirty <= '1;
      else        dirty <= (dirty & ~(fire ? 32'd1 << scan_ptr : 32'd0))
                         | (host_we ? 32'd1 << host_addr : 32'd0);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)       scan_ptr <= '0;
      else if (advance) scan_ptr <= scan_ptr + 5'd1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                gap_cnt <= '0;
      else if (fire)             gap_cnt <= CNT_W'(GAP_CYCLES);
      else if (state == S_WAIT)  gap_cnt <= gap_cnt - CNT_W'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         char_data    <= 8'h20;
         cursor_pos   <= '0;
         write_enable <= 1'b0;
      end else begin
         write_enable <= fire;
         if (fire) begin
            char_data  <= cells[scan_ptr];
            cursor_pos <= scan_ptr;
         end
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) busy <= 1'b1;
`ifdef LCD_FRAME_WRITER_FULL_REFRESH_EN
      else        busy <= 1'b1;
`else
      else        busy <= (|dirty) || state != S_SCAN;
`endif
endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb_lcd_frame_writer: scoreboard bench; expected (cell, char) writes are queued at stimulus time
// and a forked monitor pops/compares on every write_enable pulse.
module tb_lcd_frame_writer;
   localparam int GAP = 4;
   logic       clk = 1'b0, rst_n = 1'b1, host_we = 1'b0, lcd_ready = 1'b1;
   logic [4:0] host_addr = '0;
   logic [7:0] host_data = '0;
   logic [7:0] char_data;
   logic [4:0] cursor_pos;
   logic       write_enable, busy;
   int         checks = 0, errors = 0, cyc = 0;
   int         last_pulse = -1000, first_pulse = -1, pulses = 0;
   bit         keyed = 0, exact = 0;
   logic [12:0] expq [$];
   logic [7:0]  expm [int];

   lcd_frame_writer #(.GAP_CYCLES(GAP), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
      .lcd_ready(lcd_ready), .char_data(char_data), .cursor_pos(cursor_pos),
      .write_enable(write_enable), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic [7:0] pc = 8'h20;
      logic [4:0] pp = '0;
      logic [12:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pc = 8'h20; pp = '0; last_pulse = -1000;
            continue;
         end
         if (write_enable) begin
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
            if (last_pulse >= 0) begin
               if (exact) chk("pulse_spacing", cyc - last_pulse, GAP + 2);
               else       chk("pulse_min_spacing", 32'(cyc - last_pulse >= GAP + 2), 1);
            end
            last_pulse = cyc;
`ifdef LCD_FRAME_WRITER_FULL_REFRESH_EN
            chk("busy_full_refresh", busy, 1);
`endif
            if (keyed) begin
               if (expm.exists(int'(cursor_pos))) begin
                  chk("keyed_char", char_data, expm[int'(cursor_pos)]);
                  expm.delete(int'(cursor_pos));
               end else chk("unexpected_keyed_cell", cursor_pos, 32'hFFFF);
            end else if (expq.size() == 0) begin
               chk("unexpected_pulse", {cursor_pos, char_data}, 32'hFFFF);
            end else begin
               e = expq.pop_front();
               chk("cursor_pos", cursor_pos, e[12:8]);
               chk("char_data", char_data, e[7:0]);
            end
            pc = char_data; pp = cursor_pos;
         end else if ({char_data, cursor_pos} !== {pc, pp}) begin
            chk("output_stability", {char_data, cursor_pos}, {pc, pp});
            pc = char_data; pp = cursor_pos;
         end
      end
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((expq.size() != 0 || expm.size() != 0) && n < maxc) begin
         @(posedge clk);
         n++;
      end
      chk("drain_done", 32'(n < maxc), 1);
   endtask

   task automatic host_write(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      host_we = 1'b1; host_addr = a; host_data = d;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   task automatic push_frame(input int n);
      for (int i = 0; i < n; i++) expq.push_back({5'(i % 32), 8'h20});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int r, n, cnt;
      logic [4:0] a;
      logic [7:0] d;
      fork monitor(); join_none
      #3 rst_n = 1'b0;
      #1;
      chk("reset_char", char_data, 8'h20);
      chk("reset_pos", cursor_pos, 0);
      chk("reset_we", write_enable, 0);
      chk("reset_busy", busy, 1);
      exact = 1;
`ifdef LCD_FRAME_WRITER_FULL_REFRESH_EN
      push_frame(70);
`else
      push_frame(32);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      r = cyc;
      drain(3000);
      chk("first_pulse_latency", first_pulse - r, 2);
`ifndef LCD_FRAME_WRITER_FULL_REFRESH_EN
      exact = 0;
      repeat (30) @(negedge clk);
      chk("busy_idle_after_clear", busy, 0);

      expq.push_back({5'd17, 8'h41});
      host_write(5'd17, 8'h41);
      drain(500);
      repeat (20) @(negedge clk);
      chk("busy_idle_after_single", busy, 0);

      lcd_ready = 1'b0;
      do_reset();
      repeat (100) @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_no_pulses_we", write_enable, 0);
      push_frame(32);
      lcd_ready = 1'b1;
      drain(3000);
      repeat (20) @(negedge clk);
      chk("busy_after_stall_frame", busy, 0);

      lcd_ready = 1'b0;
      host_write(5'd5, 8'h41);
      repeat (40) @(negedge clk);
      expq.push_back({5'd5, 8'h41});
      expq.push_back({5'd5, 8'h42});
      lcd_ready = 1'b1; host_we = 1'b1; host_addr = 5'd5; host_data = 8'h42;
      @(negedge clk);
      host_we = 1'b0;
      drain(500);
      repeat (20) @(negedge clk);
      chk("busy_after_collision", busy, 0);

      keyed = 1;
      for (int round = 0; round < 4; round++) begin
         lcd_ready = 1'b0;
         n = $urandom_range(1, 12);
         for (int k = 0; k < n; k++) begin
            a = 5'($urandom_range(0, 31));
            d = 8'($urandom_range(32, 126));
            expm[int'(a)] = d;
            host_write(a, d);
         end
         lcd_ready = 1'b1;
         drain(2000);
         repeat (20) @(negedge clk);
         chk("busy_after_random", busy, 0);
      end
      keyed = 0;

      push_frame(32);
      do_reset();
      cnt = 0;
      while (expq.size() > 22 && cnt < 2000) begin
         @(posedge clk);
         cnt++;
      end
      chk("reached_mid_frame", 32'(cnt < 2000), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_pos", cursor_pos, 0);
      chk("midreset_char", char_data, 8'h20);
      chk("midreset_we", write_enable, 0);
      chk("midreset_busy", busy, 1);
      expq.delete();
      push_frame(32);
      @(negedge clk);
      rst_n = 1'b1;
      drain(3000);
      repeat (20) @(negedge clk);
      chk("busy_after_midreset", busy, 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lcd_frame_writer.md
# lcd_frame_writer

Upstream feeder for the 16x2 HD44780 character-LCD controller. Holds a 32-cell character frame buffer written by the host logic. It scans the buffer for changed ("dirty") cells and issues one character write per cell to the controller through its `char_data` / `cursor_pos` / `write_enable` / `ready` interface. Write pacing comes from a fixed hold-off counter, because the controller's `ready` stays high once initialisation is complete and cannot signal per-write completion.

## Interface
Parameters:
- `GAP_CYCLES`, default 10000: cycles held in WAIT after each `write_enable` pulse. Must be ≥1; 10000 covers 4 nibble strobes × 40 µs at 50 MHz.
- `CNT_W`, default 16: width of the gap counter. Must satisfy `GAP_CYCLES < 2**CNT_W`.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `host_we` in 1: host write strobe, one cell per cycle.
- `host_addr` in 5: cell index. 0–15 is line 1, 16–31 is line 2.
- `host_data` in 8: ASCII code.
- `lcd_ready` in 1: controller ready. Writes are issued only while it is 1.
- `char_data` out 8: character to the controller. Held stable between issues.
- `cursor_pos` out 5: cell index to the controller. Held stable between issues.
- `write_enable` out 1: one-cycle issue pulse.
- `busy` out 1: 1 while any cell is dirty or the FSM is not in SCAN.

## Operation
- Storage: `buf[0:31]` of 8 bits and `dirty[31:0]`, both in flops.
- Reset values:
  - every `buf` cell = 0x20 (space); `dirty` = all ones, so the screen is cleared after power-up.
  - `scan_ptr` = 0; gap counter = 0; state = SCAN.
  - `char_data` = 0x20, `cursor_pos` = 0, `write_enable` = 0, `busy` = 1.
- Host write: on a cycle with `host_we`=1, `buf[host_addr]` ← `host_data` and `dirty[host_addr]` ← 1. Writes are accepted in every state and never stall.
- FSM:
  - SCAN:
    - if `dirty[scan_ptr]`=1, go to ISSUE;
    - otherwise `scan_ptr` ← `scan_ptr`+1 (mod 32, so 31 wraps to 0) and stay in SCAN.
    - Each cycle examines exactly one cell.
  - ISSUE:
    - waits while `lcd_ready`=0; outputs are unchanged and `write_enable`=0.
    - When `lcd_ready`=1, for one cycle:
      - register `char_data` ← `buf[scan_ptr]` and `cursor_pos` ← `scan_ptr`;
      - `write_enable` ← 1 on the next cycle, aligned with the new `char_data` and `cursor_pos`;
      - clear `dirty[scan_ptr]`;
      - load the gap counter with `GAP_CYCLES`;
      - go to WAIT.
  - WAIT:
    - decrement the counter each cycle;
    - at 0: `scan_ptr` ← `scan_ptr`+1 (mod 32), go to SCAN.
- Simultaneous events:
  - A host write to `scan_ptr` in the ISSUE-fire cycle: the set wins over the clear, so the cell stays dirty. The old value is sent now and the new value is sent on a later pass.
  - A host write to `scan_ptr` during WAIT re-dirties that cell; it is rewritten on the next visit.
- `busy` = (|`dirty`) OR (state ≠ SCAN). It is registered, so it lags by one cycle.
- Fairness: round-robin from `scan_ptr`; no cell waits more than 32 issues.

## Timing
- Host write to a dirty bit: visible the next cycle.
- Idle to first pulse: from SCAN seeing a dirty cell with `lcd_ready`=1, `write_enable` rises 2 cycles later (SCAN → ISSUE → output register).
- Pulse spacing: consecutive `write_enable` pulses are separated by at least `GAP_CYCLES`+2 cycles.
- Output stability: `char_data` and `cursor_pos` change only in the ISSUE-fire cycle. They are constant from one pulse until the next fire.
- Reset mid-operation: outputs return to their reset values asynchronously; any partial transaction is abandoned, and the whole buffer is re-cleared afterwards.
- `lcd_ready` falling during WAIT has no effect until the next ISSUE.

## Configuration
- Macro `LCD_FRAME_WRITER_FULL_REFRESH_EN`.
- Defined:
  - SCAN treats every cell as dirty, so the block rewrites cells 0..31 continuously in order, one per `GAP_CYCLES`+2 cycles.
  - `busy` is constant 1 after reset.
  - `dirty` bits are still maintained but do not gate issue.
  - This mode recovers from LCD glitches.
- Undefined: only dirty cells are written, and `busy` drops to 0 once the screen is up to date.

## Test plan
- Reset with `lcd_ready`=1 and `GAP_CYCLES`=4 → 32 pulses with `char_data`=0x20 and `cursor_pos`=0,1,…,31, pulses 6 cycles apart; then `busy`=0 and no further pulses.
- After that idle, `host_we` with addr 17, data 0x41 → exactly one pulse with `cursor_pos`=17 and `char_data`=0x41; `busy` returns to 0.
- Hold `lcd_ready`=0 after reset for 100 cycles → no pulses and `busy`=1. Raise it → the first pulse carries `cursor_pos`=0 and `char_data`=0x20.
- Write 0x42 to cell 5 in the cycle ISSUE fires for cell 5 (old value 0x41) → the pulse carries 0x41, `dirty[5]` stays 1, and a later pulse carries 0x42 to cell 5.
- Assert `rst_n`=0 during WAIT midway through the frame → outputs take their reset values immediately, and the refresh restarts at cell 0 afterwards.
- With `LCD_FRAME_WRITER_FULL_REFRESH_EN` defined, no host writes for 70 pulses → `cursor_pos` sequence 0..31, 0..31, 0..5 with `busy`=1 throughout.
